// File: rtl/exbus_pkg.sv
// Shared exbus word-format constants and the header-to-chunk-count decode.
package exbus_pkg;

    localparam logic [1:0] EXB_HDR_DATA    = 2'b00;
    localparam logic [1:0] EXB_HDR_3       = 2'b01;
    localparam logic [1:0] EXB_HDR_2       = 2'b10;
    localparam logic [1:0] EXB_HDR_SPECIAL = 2'b11;

    localparam int EXB_WORDW  = 35;
    localparam int EXB_CHUNKW = 7;

    function automatic logic [2:0] exb_chunks(input logic [1:0] hdr);
        logic [2:0] n;
        n = 3'd1;
        case (hdr)
            EXB_HDR_DATA:    n = 3'd5;
            EXB_HDR_3:       n = 3'd3;
            EXB_HDR_2:       n = 3'd2;
            EXB_HDR_SPECIAL: n = 3'd1;
            default:         n = 3'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/exdeword.sv
// exdeword: serializes one 35-bit exbus word into 1..5 seven-bit chunks, MSB first.
// Build option EXDEWORD_LOWPOWER_EN zeroes o_byte/o_last/sreg whenever no byte is valid.
module exdeword
    import exbus_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_stb,
    input  logic [EXB_WORDW-1:0] i_word,
    input  logic                 i_last,
    output logic                 o_busy,
    output logic                 o_stb,
    output logic [7:0]           o_byte,
    output logic                 o_last,
    input  logic                 i_busy
);

    logic [EXB_WORDW-1:0] sreg;
    logic [2:0]           remaining;
    logic                 r_last;
    logic [2:0]           new_len;
    logic                 accept;
    logic                 advance;
    logic                 complete;
    logic                 sreg_top_unused;

    assign new_len  = exb_chunks(i_word[EXB_WORDW-1 -: 2]);
    assign o_busy   = o_stb && (i_busy || (remaining > 3'd1));
    assign accept   = i_stb && !o_busy;
    assign advance  = o_stb && !i_busy && (remaining > 3'd1);
    assign complete = o_stb && !i_busy && (remaining == 3'd1);

    // The leading chunk is taken straight from i_word, so sreg's top chunk is never read.
    assign sreg_top_unused = ^sreg[EXB_WORDW-1 -: EXB_CHUNKW];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sreg      <= '0;
            remaining <= 3'd0;
            r_last    <= 1'b0;
            o_stb     <= 1'b0;
            o_byte    <= 8'h00;
            o_last    <= 1'b0;
        end else if (accept) begin
            // Also covers the completion cycle, giving back-to-back words.
            sreg      <= i_word;
            remaining <= new_len;
            r_last    <= i_last;
            o_stb     <= 1'b1;
            o_byte    <= {1'b1, i_word[EXB_WORDW-1 -: EXB_CHUNKW]};
            o_last    <= (new_len == 3'd1) && i_last;
        end else if (advance) begin
            sreg      <= sreg << EXB_CHUNKW;
            remaining <= remaining - 3'd1;
            o_byte    <= {1'b0, sreg[EXB_WORDW-EXB_CHUNKW-1 -: EXB_CHUNKW]};
            o_last    <= (remaining == 3'd2) && r_last;
        end else if (complete) begin
            o_stb     <= 1'b0;
            remaining <= 3'd0;
`ifdef EXDEWORD_LOWPOWER_EN
            sreg      <= '0;
            o_byte    <= 8'h00;
            o_last    <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_exdeword.sv
// Bench for exdeword: directed per-cycle vector table, then randomized traffic vs a byte-queue model.
module tb_exdeword;

    logic        i_clk = 1'b0;
    logic        i_reset, i_stb, i_last, i_busy;
    logic [34:0] i_word;
    logic        o_busy, o_stb, o_last;
    logic [7:0]  o_byte;

    int tests = 0;
    int fails = 0;

    always #5 i_clk = ~i_clk;

    exdeword dut (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_stb  (i_stb),
        .i_word (i_word),
        .i_last (i_last),
        .o_busy (o_busy),
        .o_stb  (o_stb),
        .o_byte (o_byte),
        .o_last (o_last),
        .i_busy (i_busy)
    );

    // One row = one cycle: inputs driven, and the outputs expected in that same cycle.
    typedef struct {
        logic        rst, stb;
        logic [34:0] word;
        logic        last, busy;
        logic        chk, chk_data;
        logic        e_stb;
        logic [7:0]  e_byte;
        logic        e_last, e_busy;
    } vec_t;

    vec_t vecs[$];

    localparam logic [34:0] W_DATA = 35'h0_1234_5678;
    localparam logic [34:0] W_IDLE = 35'h6_C000_0000;
    localparam logic [34:0] W_HDR2 = 35'h4_0FE0_0000;

    task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic row(input logic rst, input logic stb, input logic [34:0] word, input logic last,
                       input logic busy, input logic chk, input logic chkd, input logic es,
                       input logic [7:0] eb, input logic el, input logic ebz);
        vecs.push_back('{rst, stb, word, last, busy, chk, chkd, es, eb, el, ebz});
    endtask

    // Reference model: the bytes still owed for the word in flight, head = byte on the bus.
    logic [8:0] mq[$];
    logic [7:0] m_byte;
    logic       m_last;

    function automatic int nchunks(input logic [1:0] h);
        return (h == 2'd0) ? 5 : (h == 2'd1) ? 3 : (h == 2'd2) ? 2 : 1;
    endfunction

    task automatic model_load(input logic [34:0] w, input logic l);
        int n;
        logic [34:0] s;
        n = nchunks(w[34:33]);
        for (int k = 0; k < n; k++) begin
            s = w >> (28 - 7 * k);
            mq.push_back({(k == n - 1) && l, (k == 0), s[6:0]});
        end
    endtask

    initial begin
        i_reset = 1'b1; i_stb = 1'b0; i_word = '0; i_last = 1'b0; i_busy = 1'b0;

        //   rst stb word    last busy chk chkd stb byte  last busy
        row(1, 0, 35'h0,  0, 0,   0, 0,   0, 8'h00, 0, 0);
        row(0, 1, W_DATA, 1, 0,   1, 1,   0, 8'h00, 0, 0);
        row(0, 0, 35'h0,  0, 0,   1, 1,   1, 8'h81, 0, 1);
        row(0, 0, 35'h0,  0, 0,   1, 1,   1, 8'h11, 0, 1);
        row(0, 0, 35'h0,  0, 0,   1, 1,   1, 8'h51, 0, 1);
        row(0, 0, 35'h0,  0, 0,   1, 1,   1, 8'h2C, 0, 1);
        row(0, 1, W_IDLE, 0, 0,   1, 1,   1, 8'h78, 1, 0);
        row(0, 0, 35'h0,  0, 0,   1, 1,   1, 8'hEC, 0, 0);
        // stall while the second byte is presented
        row(0, 1, W_DATA, 1, 0,   1, 0,   0, 8'h00, 0, 0);
        row(0, 0, 35'h0,  0, 0,   1, 1,   1, 8'h81, 0, 1);
        row(0, 0, 35'h0,  0, 1,   1, 1,   1, 8'h11, 0, 1);
        row(0, 0, 35'h0,  0, 1,   1, 1,   1, 8'h11, 0, 1);
        row(0, 0, 35'h0,  0, 1,   1, 1,   1, 8'h11, 0, 1);
        row(0, 0, 35'h0,  0, 0,   1, 1,   1, 8'h11, 0, 1);
        row(0, 0, 35'h0,  0, 0,   1, 1,   1, 8'h51, 0, 1);
        row(0, 0, 35'h0,  0, 0,   1, 1,   1, 8'h2C, 0, 1);
        // three idle words streamed with i_stb held
        row(0, 1, W_IDLE, 0, 0,   1, 1,   1, 8'h78, 1, 0);
        row(0, 1, W_IDLE, 0, 0,   1, 1,   1, 8'hEC, 0, 0);
        row(0, 1, W_IDLE, 0, 0,   1, 1,   1, 8'hEC, 0, 0);
        row(0, 0, 35'h0,  0, 0,   1, 1,   1, 8'hEC, 0, 0);
        // two-chunk header
        row(0, 1, W_HDR2, 1, 0,   1, 0,   0, 8'h00, 0, 0);
        row(0, 0, 35'h0,  0, 0,   1, 1,   1, 8'hC0, 0, 1);
        row(0, 0, 35'h0,  0, 0,   1, 1,   1, 8'h7F, 1, 0);
        // reset mid-word, with a competing i_stb
        row(0, 1, W_DATA, 0, 0,   1, 0,   0, 8'h00, 0, 0);
        row(0, 0, 35'h0,  0, 0,   1, 1,   1, 8'h81, 0, 1);
        row(0, 0, 35'h0,  0, 0,   1, 1,   1, 8'h11, 0, 1);
        row(1, 1, W_IDLE, 0, 0,   1, 1,   1, 8'h51, 0, 1);
        row(0, 1, W_IDLE, 0, 0,   1, 1,   0, 8'h00, 0, 0);
        row(0, 0, 35'h0,  0, 0,   1, 1,   1, 8'hEC, 0, 0);
        row(0, 0, 35'h0,  0, 0,   1, 0,   0, 8'h00, 0, 0);

        @(negedge i_clk);
        foreach (vecs[i]) begin
            i_reset = vecs[i].rst; i_stb = vecs[i].stb; i_word = vecs[i].word;
            i_last = vecs[i].last; i_busy = vecs[i].busy;
            #1;
            if (vecs[i].chk) begin
                check("dir_stb", i, {7'd0, o_stb}, {7'd0, vecs[i].e_stb});
                check("dir_busy", i, {7'd0, o_busy}, {7'd0, vecs[i].e_busy});
            end
            if (vecs[i].chk_data) begin
                check("dir_byte", i, o_byte, vecs[i].e_byte);
                check("dir_last", i, {7'd0, o_last}, {7'd0, vecs[i].e_last});
            end
            @(posedge i_clk);
            @(negedge i_clk);
        end

        // Randomized phase; upstream holds a pending word until the model says it was taken.
        begin
            logic [34:0] pw;
            logic        pl, pend, rst, busy, mbusy, acc;
            pw = '0; pl = 1'b0; pend = 1'b0;
            i_reset = 1'b1; i_stb = 1'b0; i_busy = 1'b0;
            @(posedge i_clk);
            @(negedge i_clk);
            mq.delete(); m_byte = 8'h00; m_last = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                rst  = ($urandom_range(0, 199) == 0);
                busy = ($urandom_range(0, 9) < 3);
                if (!pend && ($urandom_range(0, 9) < 6)) begin
                    pend = 1'b1;
                    pw   = {3'($urandom), 32'($urandom)};
                    pl   = 1'($urandom);
                end
                i_reset = rst; i_stb = pend; i_word = pw; i_last = pl; i_busy = busy;
                #1;
                mbusy = (mq.size() > 0) && (busy || (mq.size() > 1));
                check("rnd_stb", c, {7'd0, o_stb}, {7'd0, mq.size() > 0});
                check("rnd_busy", c, {7'd0, o_busy}, {7'd0, mbusy});
                check("rnd_byte", c, o_byte, m_byte);
                check("rnd_last", c, {7'd0, o_last}, {7'd0, m_last});
                if (rst) begin
                    mq.delete(); m_byte = 8'h00; m_last = 1'b0;
                end else begin
                    acc = pend && !mbusy;
                    if ((mq.size() > 0) && !busy) void'(mq.pop_front());
                    if (acc) begin
                        model_load(pw, pl);
                        pend = 1'b0;
                    end
                    if (mq.size() > 0) {m_last, m_byte} = mq[0];
`ifdef EXDEWORD_LOWPOWER_EN
                    else begin
                        m_last = 1'b0; m_byte = 8'h00;
                    end
`endif
                end
                @(posedge i_clk);
                @(negedge i_clk);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
